// File: rtl/mano_control_unit.sv
// -----------------------------------------------------------------------------
// mano_control_unit
//   Hardwired control unit for the Mano basic computer. It holds a 4-bit
//   sequence counter (SC), the indirect-bit flip-flop (I) and a halted flag.
//   Every control output is decoded combinationally from SC, I, ir, halted
//   and the datapath status bits.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high reset
//   ir       in   [15]=I, [14:12]=D opcode, [11:0]=address / register-ref bits
//   ac_zero  in   AC == 0
//   ac_msb   in   AC[15]
//   dr_zero  in   DR == 0
//   e_flag   in   E flip-flop
//   bus_sel  out  common-bus source (0 none,1 AR,2 PC,3 DR,4 AC,5 IR,6 TR,7 MEM)
//   ld/inc/clr out per-register controls, [0]AR [1]PC [2]DR [3]AC [4]IR [5]TR
//   mem_rd   out  memory read strobe at AR
//   mem_wr   out  memory write strobe at AR
//   alu_op   out  0 none,1 AND,2 ADD,3 pass DR,4 CMA,5 CIR,6 CIL
//   e_op     out  0 hold,1 clear,2 complement,3 load carry
//   sc       out  sequence counter value
//   halted   out  HLT has executed
// -----------------------------------------------------------------------------
module mano_control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir,
  input  logic        ac_zero,
  input  logic        ac_msb,
  input  logic        dr_zero,
  input  logic        e_flag,
  output logic [2:0]  bus_sel,
  output logic [5:0]  ld,
  output logic [5:0]  inc,
  output logic [5:0]  clr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [2:0]  alu_op,
  output logic [1:0]  e_op,
  output logic [3:0]  sc,
  output logic        halted
);

  // Register indices into ld/inc/clr.
  localparam int AR = 0;
  localparam int PC = 1;
  localparam int DR = 2;
  localparam int AC = 3;
  localparam int IR = 4;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0, BUS_AR = 3'd1, BUS_PC = 3'd2, BUS_DR = 3'd3,
    BUS_AC   = 3'd4, BUS_IR = 3'd5, BUS_TR = 3'd6, BUS_MEM = 3'd7
  } bus_e;

  typedef enum logic [2:0] {
    ALU_NONE = 3'd0, ALU_AND = 3'd1, ALU_ADD = 3'd2, ALU_DR = 3'd3,
    ALU_CMA  = 3'd4, ALU_CIR = 3'd5, ALU_CIL = 3'd6
  } alu_e;

  logic [3:0] sc_q, sc_d;
  logic       i_q, i_d;
  logic       halted_q, halted_d;
  logic [2:0] d;

  assign d      = ir[14:12];
  assign sc     = sc_q;
  assign halted = halted_q;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (reset) begin
      sc_q     <= 4'd0;
      i_q      <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      sc_q     <= sc_d;
      i_q      <= i_d;
      halted_q <= halted_d;
    end
  end

  // Next-state logic: SC counts up unless the current step ends the
  // instruction.
  always_comb begin
    // NOTE: defaults first so no path through the block leaves a signal
    // unassigned (which would infer a latch).
    sc_d     = sc_q + 4'd1;
    i_d      = i_q;
    halted_d = halted_q;
    if (halted_q) begin
      sc_d = 4'd0;
    end else begin
      unique case (sc_q)
        4'd0, 4'd1: ;
        4'd2: i_d = ir[15];
        4'd3: begin
          if (d == 3'd7) begin
            sc_d = 4'd0;
            if (!i_q && ir[0]) halted_d = 1'b1;
          end
        end
        4'd4: if (d == 3'd3 || d == 3'd4) sc_d = 4'd0;
        4'd5: if (d inside {3'd0, 3'd1, 3'd2, 3'd5}) sc_d = 4'd0;
        default: sc_d = 4'd0;  // T6 ends ISZ; 7..15 are unreachable
      endcase
    end
  end

  // Output decode.
  always_comb begin
    bus_sel = BUS_NONE;
    ld      = '0;
    inc     = '0;
    clr     = '0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    alu_op  = ALU_NONE;
    e_op    = 2'd0;
    // Reset and halt both silence every control.
    if (!reset && !halted_q) begin
      unique case (sc_q)
        4'd0: begin
          bus_sel = BUS_PC;
          ld[AR]  = 1'b1;
        end
        4'd1: begin
          bus_sel = BUS_MEM;
          mem_rd  = 1'b1;
          ld[IR]  = 1'b1;
          inc[PC] = 1'b1;
        end
        4'd2: begin
          bus_sel = BUS_IR;
          ld[AR]  = 1'b1;
        end
        4'd3: begin
          if (d != 3'd7) begin
            if (i_q) begin
              bus_sel = BUS_MEM;
              mem_rd  = 1'b1;
              ld[AR]  = 1'b1;
            end
          end else if (!i_q) begin
            // Register-reference bits act in parallel.
            clr[AC] = ir[11];
            inc[AC] = ir[5];
            if (ir[10])     e_op = 2'd1;
            else if (ir[8]) e_op = 2'd2;
            if (ir[9]) begin
              ld[AC] = 1'b1;
              alu_op = ALU_CMA;
            end else if (ir[7]) begin
              ld[AC] = 1'b1;
              alu_op = ALU_CIR;
            end else if (ir[6]) begin
              ld[AC] = 1'b1;
              alu_op = ALU_CIL;
            end
            inc[PC] = (ir[4] && !ac_msb) || (ir[3] && ac_msb) ||
                      (ir[2] && ac_zero) || (ir[1] && !e_flag);
          end
        end
        4'd4: begin
          unique case (d)
            3'd0, 3'd1, 3'd2, 3'd6: begin
              bus_sel = BUS_MEM;
              mem_rd  = 1'b1;
              ld[DR]  = 1'b1;
            end
            3'd3: begin
              bus_sel = BUS_AC;
              mem_wr  = 1'b1;
            end
            3'd4: begin
              bus_sel = BUS_AR;
              ld[PC]  = 1'b1;
            end
            3'd5: begin
              bus_sel = BUS_PC;
              mem_wr  = 1'b1;
              inc[AR] = 1'b1;
            end
            default: ;
          endcase
        end
        4'd5: begin
          unique case (d)
            3'd0, 3'd1, 3'd2: begin
              ld[AC] = 1'b1;
              alu_op = d + 3'd1;     // AND/ADD/LDA map to 1/2/3
              if (d == 3'd1) e_op = 2'd3;
            end
            3'd5: begin
              bus_sel = BUS_AR;
              ld[PC]  = 1'b1;
            end
            3'd6: inc[DR] = 1'b1;
            default: ;
          endcase
        end
        4'd6: begin
          if (d == 3'd6) begin
            bus_sel = BUS_DR;
            mem_wr  = 1'b1;
            inc[PC] = dr_zero;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mano_control_unit.sv
// -----------------------------------------------------------------------------
// tb_mano_control_unit
//   Self-checking bench for mano_control_unit. A reference model expands each
//   instruction into its list of expected micro-steps, which are compared
//   cycle by cycle against the DUT. Directed cases cover the worked examples,
//   halt behaviour and mid-instruction reset; random instructions follow.
// -----------------------------------------------------------------------------
module tb_mano_control_unit;

  typedef struct packed {
    logic [2:0] sel;
    logic [5:0] ld;
    logic [5:0] inc;
    logic [5:0] clr;
    logic       rd;
    logic       wr;
    logic [2:0] alu;
    logic [1:0] eop;
  } ctl_t;

  localparam int AR = 0, PC = 1, DR = 2, AC = 3, IR = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ir;
  logic        ac_zero, ac_msb, dr_zero, e_flag;
  logic [2:0]  bus_sel;
  logic [5:0]  ld, inc, clr;
  logic        mem_rd, mem_wr;
  logic [2:0]  alu_op;
  logic [1:0]  e_op;
  logic [3:0]  sc;
  logic        halted;

  ctl_t dut_ctl;
  assign dut_ctl = {bus_sel, ld, inc, clr, mem_rd, mem_wr, alu_op, e_op};

  int checks   = 0;
  int failures = 0;

  ctl_t exp_q[$];

  mano_control_unit dut (
    .clk(clk), .reset(reset), .ir(ir),
    .ac_zero(ac_zero), .ac_msb(ac_msb), .dr_zero(dr_zero), .e_flag(e_flag),
    .bus_sel(bus_sel), .ld(ld), .inc(inc), .clr(clr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .alu_op(alu_op), .e_op(e_op),
    .sc(sc), .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout reached before summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ctl_t mk(input logic [2:0] sel);
    ctl_t c;
    c = '0;
    c.sel = sel;
    return c;
  endfunction

  // Expand an instruction into its sequence of expected per-cycle controls.
  function automatic void build(input logic [15:0] instr, input logic az,
                                input logic am, input logic dz, input logic ef);
    ctl_t c;
    int op;
    logic ind;
    op  = int'(instr[14:12]);
    ind = instr[15];
    exp_q.delete();
    c = mk(3'd2); c.ld[AR] = 1'b1; exp_q.push_back(c);
    c = mk(3'd7); c.rd = 1'b1; c.ld[IR] = 1'b1; c.inc[PC] = 1'b1; exp_q.push_back(c);
    c = mk(3'd5); c.ld[AR] = 1'b1; exp_q.push_back(c);
    if (op == 7) begin
      c = mk(3'd0);
      if (!ind) begin
        c.clr[AC] = instr[11];
        c.inc[AC] = instr[5];
        c.eop = instr[10] ? 2'd1 : (instr[8] ? 2'd2 : 2'd0);
        if (instr[9] || instr[7] || instr[6]) begin
          c.ld[AC] = 1'b1;
          c.alu = instr[9] ? 3'd4 : (instr[7] ? 3'd5 : 3'd6);
        end
        c.inc[PC] = (instr[4] && am == 1'b0) || (instr[3] && am == 1'b1) ||
                    (instr[2] && az == 1'b1) || (instr[1] && ef == 1'b0);
      end
      exp_q.push_back(c);
      return;
    end
    c = mk(ind ? 3'd7 : 3'd0);
    if (ind) begin c.rd = 1'b1; c.ld[AR] = 1'b1; end
    exp_q.push_back(c);
    case (op)
      0, 1, 2: begin
        c = mk(3'd7); c.rd = 1'b1; c.ld[DR] = 1'b1; exp_q.push_back(c);
        c = mk(3'd0); c.ld[AC] = 1'b1; c.alu = 3'(op + 1);
        if (op == 1) c.eop = 2'd3;
        exp_q.push_back(c);
      end
      3: begin c = mk(3'd4); c.wr = 1'b1; exp_q.push_back(c); end
      4: begin c = mk(3'd1); c.ld[PC] = 1'b1; exp_q.push_back(c); end
      5: begin
        c = mk(3'd2); c.wr = 1'b1; c.inc[AR] = 1'b1; exp_q.push_back(c);
        c = mk(3'd1); c.ld[PC] = 1'b1; exp_q.push_back(c);
      end
      default: begin
        c = mk(3'd7); c.rd = 1'b1; c.ld[DR] = 1'b1; exp_q.push_back(c);
        c = mk(3'd0); c.inc[DR] = 1'b1; exp_q.push_back(c);
        c = mk(3'd3); c.wr = 1'b1; c.inc[PC] = dz; exp_q.push_back(c);
      end
    endcase
  endfunction

  // Called positioned #1 after an edge in a cycle that should be T0.
  // Runs the first n_steps expected steps (all if n_steps < 0).
  task automatic run_instr(input string tag, input logic [15:0] instr, input logic az,
                           input logic am, input logic dz, input logic ef,
                           input int n_steps);
    int n;
    build(instr, az, am, dz, ef);
    ir = instr; ac_zero = az; ac_msb = am; dr_zero = dz; e_flag = ef;
    n = (n_steps < 0) ? exp_q.size() : n_steps;
    for (int t = 0; t < n; t++) begin
      #1;
      check($sformatf("%s_T%0d_sc", tag, t), 32'(sc), 32'(t));
      check($sformatf("%s_T%0d_ctl", tag, t), 32'(dut_ctl), 32'(exp_q[t]));
      check($sformatf("%s_T%0d_halted", tag, t), 32'(halted), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_ctl_zero", 32'(dut_ctl), 32'd0);
    check("rst_sc", 32'(sc), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    ctl_t t0_ctl, t1_ctl;
    logic [15:0] rnd_ir;
    reset = 1'b1; ir = 16'h5123;
    ac_zero = 1'b0; ac_msb = 1'b0; dr_zero = 1'b0; e_flag = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Worked examples.
    run_instr("lda_direct", 16'h2005, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    check("lda_next_sc", 32'(sc), 32'd0);
    run_instr("add_indirect", 16'h9010, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    run_instr("isz_dz1", 16'h6020, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    run_instr("isz_dz0", 16'h6020, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    run_instr("skip_taken", 16'h7014, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    run_instr("skip_not", 16'h7014, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    run_instr("sta", 16'h3abc, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    run_instr("bun_ind", 16'hc004, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    run_instr("io_group", 16'hf800, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    run_instr("regref_all", 16'h7fe2, 1'b0, 1'b0, 1'b0, 1'b1, -1);

    // Halt: silent and parked for 20 cycles, then cleared by reset.
    run_instr("hlt", 16'h7001, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    for (int k = 0; k < 20; k++) begin
      ir = 16'($urandom);
      #1;
      check($sformatf("halt_%0d_halted", k), 32'(halted), 32'd1);
      check($sformatf("halt_%0d_sc", k), 32'(sc), 32'd0);
      check($sformatf("halt_%0d_ctl", k), 32'(dut_ctl), 32'd0);
      @(posedge clk); #1;
    end
    do_reset();
    build(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    t0_ctl = exp_q[0];
    t1_ctl = exp_q[1];
    #1;
    check("post_halt_t0", 32'(dut_ctl), 32'(t0_ctl));

    // Reset pulsed during T4 of BSA.
    run_instr("bsa_abort", 16'h5123, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    check("bsa_at_t4_sc", 32'(sc), 32'd4);
    reset = 1'b1;
    #1;
    check("bsa_rst_ctl", 32'(dut_ctl), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("bsa_after_sc", 32'(sc), 32'd0);
    check("bsa_after_wr", 32'(mem_wr), 32'd0);
    check("bsa_after_inc", 32'(inc), 32'd0);
    check("bsa_after_t0", 32'(dut_ctl), 32'(t0_ctl));
    @(posedge clk); #1;
    check("bsa_after_t1_sc", 32'(sc), 32'd1);
    check("bsa_after_t1", 32'(dut_ctl), 32'(t1_ctl));
    do_reset();

    // Random instructions (HLT masked out so the run continues).
    for (int n = 0; n < 60; n++) begin
      rnd_ir = 16'($urandom);
      if (rnd_ir[14:12] == 3'd7 && !rnd_ir[15]) rnd_ir[0] = 1'b0;
      run_instr($sformatf("rnd%0d_%h", n, rnd_ir), rnd_ir,
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), -1);
    end
    #1;
    check("final_sc", 32'(sc), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mano_control_unit.md
MANO_CONTROL_UNIT -- requirements
Module: mano_control_unit

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have: reset  in  1  reset; synchronous and active-high, sampled on the rising edge of clk.
REQ-003 SHALL have: ir  in  16  instruction register contents; [15]=I, [14:12]=D opcode, [11:0]=address or register-ref bits.
REQ-004 SHALL have: ac_zero, ac_msb, dr_zero, e_flag  in  1 each  datapath status: AC==0, AC[15], DR==0, E.
REQ-005 SHALL have: bus_sel  out  3  common-bus source: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEM.
REQ-006 SHALL have: ld, inc, clr  out  6 each  per-register controls; bit order [0]AR [1]PC [2]DR [3]AC [4]IR [5]TR.
REQ-007 SHALL have: mem_rd, mem_wr  out  1 each  memory read/write strobes at address AR.
REQ-008 SHALL have: alu_op  out  3  operation: 0 none, 1 AND, 2 ADD, 3 pass DR, 4 CMA, 5 CIR, 6 CIL; AC loads only when ld[3]=1.
REQ-009 SHALL have: e_op  out  2  E control: 0 hold, 1 clear, 2 complement, 3 load carry.
REQ-010 SHALL have: sc  out  4  sequence counter value; halted  out  1  HLT executed.

Function
REQ-011 SHALL hold a 4-bit sequence counter SC, an I flip-flop and a halted flag as its only state.
REQ-012 SHALL drive all outputs combinationally from SC, I, ir, halted and the status inputs; unlisted controls are 0.
REQ-013 SHALL increment SC by 1 each cycle unless an action below clears it; "SC<-0" means SC=0 next cycle.
REQ-014 At T0, SHALL set bus_sel=2 and ld[AR]=1.
REQ-015 At T1, SHALL set bus_sel=7, mem_rd=1, ld[IR]=1 and inc[PC]=1.
REQ-016 At T2, SHALL set bus_sel=5 and ld[AR]=1, and capture I<-ir[15] at the clock edge.
REQ-017 At T3 with D!=7 and I=1, SHALL set bus_sel=7, mem_rd=1 and ld[AR]=1; with D!=7 and I=0, SHALL assert no controls.
REQ-018 At T3 with D=7 and I=1 (I/O group, unsupported), SHALL assert no controls and SC<-0.
REQ-019 At T3 with D=7 and I=0, SHALL decode register-reference bits in parallel and SC<-0.
REQ-019a Bit 11 CLA SHALL set clr[AC]; bit 5 INC SHALL set inc[AC].
REQ-019b Bit 10 CLE SHALL set e_op=1; otherwise bit 8 CME SHALL set e_op=2.
REQ-019c For bits 9 CMA, 7 CIR and 6 CIL, SHALL set ld[AC] with alu_op 4, 5 or 6, priority CMA > CIR > CIL.
REQ-019d Skips SHALL set inc[PC] when any enabled condition holds: bit 4 SPA (ac_msb=0), bit 3 SNA (ac_msb=1), bit 2 SZA (ac_zero=1), bit 1 SZE (e_flag=0).
REQ-019e Bit 0 HLT SHALL set halted<-1.
REQ-020 AND/ADD/LDA (D=0/1/2): at T4, SHALL set bus_sel=7, mem_rd and ld[DR]; at T5, SHALL set ld[AC] with alu_op 1/2/3 and SC<-0.
REQ-020a For ADD at T5, SHALL also set e_op=3.
REQ-021 STA (D=3): at T4, SHALL set bus_sel=4 and mem_wr, then SC<-0.
REQ-022 BUN (D=4): at T4, SHALL set bus_sel=1 and ld[PC], then SC<-0.
REQ-023 BSA (D=5): at T4, SHALL set bus_sel=2, mem_wr and inc[AR]; at T5, SHALL set bus_sel=1 and ld[PC], then SC<-0.
REQ-024 ISZ (D=6): at T4, SHALL set bus_sel=7, mem_rd and ld[DR]; at T5, SHALL set inc[DR].
REQ-024a For ISZ at T6, SHALL set bus_sel=3 and mem_wr, set inc[PC] if dr_zero=1, then SC<-0.
REQ-025 SHALL never set mem_rd and mem_wr together; bus_sel SHALL be 0 whenever no transfer is listed.
REQ-026 While halted=1, SHALL hold SC=0 and drive all controls to 0 until reset.
REQ-027 SC SHALL never exceed 6; an unreachable SC value SHALL force SC<-0 with no controls.

Reset
REQ-028 When reset=1 at a clock edge, SHALL set SC=0, I=0 and halted=0, overriding any other update.
REQ-029 While reset=1, SHALL drive all control outputs to 0; the first cycle after reset is T0.
REQ-030 Reset asserted mid-instruction (any T) SHALL abort it; no further controls from that instruction.

Verification
REQ-031 Reset, then ir=16'h2005 (LDA direct) -> T0 ld=000001 sel=2; T1 sel=7 mem_rd ld[IR] inc[PC]; T2 sel=5; T3 idle; T4 ld[DR]; T5 ld[AC] alu_op=3; next SC=0.
REQ-032 ir=16'h9010 (ADD indirect) -> T3 sel=7 mem_rd ld[AR]; T5 alu_op=2 e_op=3 ld[AC].
REQ-033 ir=16'h6020 (ISZ) with dr_zero=1 at T6 -> sel=3, mem_wr=1, inc[PC]=1; with dr_zero=0, inc[PC]=0.
REQ-034 ir=16'h7014 (SPA|SZA) with ac_msb=1, ac_zero=1 -> T3 inc[PC]=1; ac_msb=1, ac_zero=0 -> inc[PC]=0.
REQ-035 ir=16'h7001 (HLT) -> halted=1 from next cycle; SC stays 0 and all controls stay 0 for 20 cycles; reset clears halted.
REQ-036 Reset pulsed at T4 of BSA -> next cycle SC=0, mem_wr=0, inc=0, and the following cycle performs a T0 fetch.
